// File: rtl/cs_mseq.sv
// Microsequencer: picks the next control-store address each cycle, and stalls
// the MIR while a memory access waits for its acknowledge (with a timeout trap).
module cs_mseq #(
    parameter int                          MSEQ_LENGTH_ADDR = 11,
    parameter int                          MSEQ_LENGTH_COND = 3,
    parameter int                          MSEQ_MEM_TIMEOUT = 16,
    parameter logic [MSEQ_LENGTH_ADDR-1:0] MSEQ_TRAP_ADDR   = 11'h7F0
) (
    input  logic                        CS_MSEQ_CLOCK_50,
    input  logic                        CS_MSEQ_RESET_InHigh,
    input  logic [MSEQ_LENGTH_COND-1:0] CS_MSEQ_COND_data_InBUS,
    input  logic [MSEQ_LENGTH_ADDR-1:0] CS_MSEQ_ADDRESS_data_InBUS,
    input  logic                        CS_MSEQ_RD_data_In,
    input  logic                        CS_MSEQ_WR_data_In,
    input  logic                        CS_MSEQ_N_In,
    input  logic                        CS_MSEQ_Z_In,
    input  logic                        CS_MSEQ_V_In,
    input  logic                        CS_MSEQ_C_In,
    input  logic [31:0]                 CS_MSEQ_IR_data_InBUS,
    input  logic                        CS_MSEQ_MEMACK_In,
    output logic [MSEQ_LENGTH_ADDR-1:0] CS_MSEQ_NEXTADDR_data_OutBUS,
    output logic [MSEQ_LENGTH_ADDR-1:0] CS_MSEQ_MPC_data_OutBUS,
    output logic                        CS_MSEQ_MIRload_OutLow,
    output logic                        CS_MSEQ_STALL_Out,
    output logic                        CS_MSEQ_ERROR_Out
);
    localparam int CW = $clog2(MSEQ_MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_START, S_RUN, S_WAIT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [MSEQ_LENGTH_ADDR-1:0] r_mpc;
    logic [CW-1:0]               r_cnt;
    logic                        r_error;

    logic [MSEQ_LENGTH_ADDR-1:0] w_inc;
    logic [MSEQ_LENGTH_ADDR-1:0] w_decode;
    logic [MSEQ_LENGTH_ADDR-1:0] w_target;
    logic [MSEQ_LENGTH_ADDR-1:0] w_nextaddr;
    logic                        w_mem;
    logic                        w_timeout;
    logic                        w_load;
    logic                        w_trap;
    logic                        w_mirn;
    logic                        w_stall;
    logic                        w_unused_ir;

    assign w_inc       = r_mpc + MSEQ_LENGTH_ADDR'(1);
    assign w_decode    = MSEQ_LENGTH_ADDR'({1'b1, CS_MSEQ_IR_data_InBUS[31:30],
                                            CS_MSEQ_IR_data_InBUS[24:19], 2'b00});
    assign w_unused_ir = &{CS_MSEQ_IR_data_InBUS[29:25], CS_MSEQ_IR_data_InBUS[18:14],
                           CS_MSEQ_IR_data_InBUS[12:0]};
    // RD and WR together still form one handshake
    assign w_mem       = CS_MSEQ_RD_data_In | CS_MSEQ_WR_data_In;
    assign w_timeout   = (r_cnt >= CW'(MSEQ_MEM_TIMEOUT));

    always_comb begin
        w_target = w_inc;
        case (CS_MSEQ_COND_data_InBUS)
            3'b000: w_target = w_inc;
            3'b001: w_target = CS_MSEQ_N_In ? CS_MSEQ_ADDRESS_data_InBUS : w_inc;
            3'b010: w_target = CS_MSEQ_Z_In ? CS_MSEQ_ADDRESS_data_InBUS : w_inc;
            3'b011: w_target = CS_MSEQ_V_In ? CS_MSEQ_ADDRESS_data_InBUS : w_inc;
            3'b100: w_target = CS_MSEQ_C_In ? CS_MSEQ_ADDRESS_data_InBUS : w_inc;
            3'b101: w_target = CS_MSEQ_IR_data_InBUS[13] ? CS_MSEQ_ADDRESS_data_InBUS : w_inc;
            3'b110: w_target = CS_MSEQ_ADDRESS_data_InBUS;
            default: w_target = w_decode;
        endcase
    end

    always_ff @(posedge CS_MSEQ_CLOCK_50 or posedge CS_MSEQ_RESET_InHigh) begin
        if (CS_MSEQ_RESET_InHigh) r_state <= S_START;
        else                      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_START: w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = (w_mem && !CS_MSEQ_MEMACK_In) ? S_WAIT : S_RUN;
            S_WAIT:  w_state_nxt = (CS_MSEQ_MEMACK_In || w_timeout) ? S_RUN : S_WAIT;
            default: w_state_nxt = S_START;
        endcase
    end

    always_comb begin
        w_nextaddr = '0;
        w_mirn     = 1'b0;
        w_stall    = 1'b0;
        w_load     = 1'b0;
        w_trap     = 1'b0;
        case (r_state)
            S_START: w_load = 1'b1;
            S_RUN: begin
                if (w_mem && !CS_MSEQ_MEMACK_In) begin
                    w_nextaddr = r_mpc;
                    w_mirn     = 1'b1;
                    w_stall    = 1'b1;
                end else begin
                    w_nextaddr = w_target;
                    w_load     = 1'b1;
                end
            end
            S_WAIT: begin
                // acknowledge wins over a simultaneous timeout
                if (CS_MSEQ_MEMACK_In) begin
                    w_nextaddr = w_target;
                    w_load     = 1'b1;
                end else if (w_timeout) begin
                    w_nextaddr = MSEQ_TRAP_ADDR;
                    w_stall    = 1'b1;
                    w_load     = 1'b1;
                    w_trap     = 1'b1;
                end else begin
                    w_nextaddr = r_mpc;
                    w_mirn     = 1'b1;
                    w_stall    = 1'b1;
                end
            end
            default: w_load = 1'b1;
        endcase
    end

    always_ff @(posedge CS_MSEQ_CLOCK_50 or posedge CS_MSEQ_RESET_InHigh) begin
        if (CS_MSEQ_RESET_InHigh) begin
            r_mpc   <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_load) r_mpc <= w_nextaddr;
            if (w_state_nxt == S_WAIT)
                r_cnt <= (r_state == S_WAIT) ? r_cnt + CW'(1) : CW'(1);
            else
                r_cnt <= '0;
            if (w_trap) r_error <= 1'b1;
        end
    end

    assign CS_MSEQ_NEXTADDR_data_OutBUS = w_nextaddr;
    assign CS_MSEQ_MPC_data_OutBUS      = r_mpc;
    assign CS_MSEQ_MIRload_OutLow       = w_mirn;
    assign CS_MSEQ_STALL_Out            = w_stall;
    assign CS_MSEQ_ERROR_Out            = r_error;
endmodule

// File: tb/tb_cs_mseq.sv
// Directed bench for cs_mseq: branch table vectors, then wait/timeout/reset sequences.
module tb_cs_mseq;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cond;
    logic [10:0] addr;
    logic        rd, wr, n, z, v, c, ack;
    logic [31:0] ir;
    logic [10:0] na, mpc;
    logic        mirn, stall, err;

    int total = 0;
    int bad   = 0;

    cs_mseq dut (
        .CS_MSEQ_CLOCK_50            (clk),
        .CS_MSEQ_RESET_InHigh        (rst),
        .CS_MSEQ_COND_data_InBUS     (cond),
        .CS_MSEQ_ADDRESS_data_InBUS  (addr),
        .CS_MSEQ_RD_data_In          (rd),
        .CS_MSEQ_WR_data_In          (wr),
        .CS_MSEQ_N_In                (n),
        .CS_MSEQ_Z_In                (z),
        .CS_MSEQ_V_In                (v),
        .CS_MSEQ_C_In                (c),
        .CS_MSEQ_IR_data_InBUS       (ir),
        .CS_MSEQ_MEMACK_In           (ack),
        .CS_MSEQ_NEXTADDR_data_OutBUS(na),
        .CS_MSEQ_MPC_data_OutBUS     (mpc),
        .CS_MSEQ_MIRload_OutLow      (mirn),
        .CS_MSEQ_STALL_Out           (stall),
        .CS_MSEQ_ERROR_Out           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cond;
        logic [10:0] addr;
        logic        rd, wr;
        logic [3:0]  nzvc;
        logic [31:0] ir;
        logic        ack;
        logic [10:0] na, mpc;
        logic        stall, mirn, err;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [10:0] e_na, input logic [10:0] e_mpc,
                           input logic e_stall, input logic e_mirn, input logic e_err);
        chk({tag, ".nextaddr"}, 32'(na), 32'(e_na));
        chk({tag, ".mpc"}, 32'(mpc), 32'(e_mpc));
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".mirload_n"}, 32'(mirn), 32'(e_mirn));
        chk({tag, ".error"}, 32'(err), 32'(e_err));
    endtask

    // Drive at a falling edge, check 1ns later, then move to the next falling edge
    task automatic step(input string tag, input logic [2:0] i_cond, input logic [10:0] i_addr,
                        input logic i_rd, input logic i_wr, input logic [3:0] i_nzvc,
                        input logic [31:0] i_ir, input logic i_ack,
                        input logic [10:0] e_na, input logic [10:0] e_mpc,
                        input logic e_stall, input logic e_mirn, input logic e_err);
        cond = i_cond; addr = i_addr; rd = i_rd; wr = i_wr;
        {n, z, v, c} = i_nzvc; ir = i_ir; ack = i_ack;
        #1;
        chk_out(tag, e_na, e_mpc, e_stall, e_mirn, e_err);
        @(negedge clk);
    endtask

    // Memory access at MPC=m that never completes; ends with MPC=7F0 in RUN
    task automatic do_timeout(input string tag, input logic [10:0] m, input logic e_err);
        step({tag, ".run"}, 3'd0, 11'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, m, m, 1'b1, 1'b1, e_err);
        for (int i = 1; i < 16; i++)
            step($sformatf("%s.w%0d", tag, i), 3'd0, 11'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0,
                 m, m, 1'b1, 1'b1, e_err);
        step({tag, ".trap"}, 3'd0, 11'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0,
             11'h7F0, m, 1'b1, 1'b0, e_err);
    endtask

    initial begin
        //          cond  addr     rd wr nzvc  ir            ack  na       mpc     st mi er
        tbl[0]  = '{3'd0, 11'h000, 0, 0, 4'h0, 32'h0,        0, 11'h000, 11'h000, 0, 0, 0};
        tbl[1]  = '{3'd0, 11'h000, 0, 0, 4'h0, 32'h0,        0, 11'h001, 11'h000, 0, 0, 0};
        tbl[2]  = '{3'd0, 11'h000, 0, 0, 4'h0, 32'h0,        0, 11'h002, 11'h001, 0, 0, 0};
        tbl[3]  = '{3'd0, 11'h000, 0, 0, 4'h0, 32'h0,        0, 11'h003, 11'h002, 0, 0, 0};
        tbl[4]  = '{3'd2, 11'h155, 0, 0, 4'h4, 32'h0,        0, 11'h155, 11'h003, 0, 0, 0};
        tbl[5]  = '{3'd2, 11'h155, 0, 0, 4'hB, 32'h0,        0, 11'h156, 11'h155, 0, 0, 0};
        tbl[6]  = '{3'd1, 11'h7FF, 0, 0, 4'h8, 32'h0,        0, 11'h7FF, 11'h156, 0, 0, 0};
        tbl[7]  = '{3'd0, 11'h123, 0, 0, 4'hF, 32'h0,        0, 11'h000, 11'h7FF, 0, 0, 0};
        tbl[8]  = '{3'd3, 11'h200, 0, 0, 4'hD, 32'h0,        0, 11'h001, 11'h000, 0, 0, 0};
        tbl[9]  = '{3'd3, 11'h200, 0, 0, 4'h2, 32'h0,        0, 11'h200, 11'h001, 0, 0, 0};
        tbl[10] = '{3'd4, 11'h0AA, 0, 0, 4'h1, 32'h0,        0, 11'h0AA, 11'h200, 0, 0, 0};
        tbl[11] = '{3'd4, 11'h0AA, 0, 0, 4'hE, 32'h0,        0, 11'h0AB, 11'h0AA, 0, 0, 0};
        tbl[12] = '{3'd5, 11'h123, 0, 0, 4'h0, 32'h00002000, 0, 11'h123, 11'h0AB, 0, 0, 0};
        tbl[13] = '{3'd5, 11'h321, 0, 0, 4'hF, 32'hFFFFDFFF, 0, 11'h124, 11'h123, 0, 0, 0};
        tbl[14] = '{3'd6, 11'h055, 0, 0, 4'h0, 32'h0,        0, 11'h055, 11'h124, 0, 0, 0};
        tbl[15] = '{3'd7, 11'h000, 0, 0, 4'h0, 32'hC0F80000, 0, 11'h77C, 11'h055, 0, 0, 0};
        tbl[16] = '{3'd7, 11'h000, 0, 0, 4'h0, 32'hC1F80000, 0, 11'h7FC, 11'h77C, 0, 0, 0};
        tbl[17] = '{3'd7, 11'h3FF, 0, 0, 4'hF, 32'h4A380000, 0, 11'h51C, 11'h7FC, 0, 0, 0};
        tbl[18] = '{3'd0, 11'h000, 1, 0, 4'h0, 32'h0,        1, 11'h51D, 11'h51C, 0, 0, 0};
        tbl[19] = '{3'd6, 11'h010, 1, 1, 4'h0, 32'h0,        1, 11'h010, 11'h51D, 0, 0, 0};

        rst = 1'b1; cond = '0; addr = '0; rd = 0; wr = 0;
        {n, z, v, c} = 4'h0; ir = '0; ack = 0;
        #2;
        chk_out("reset", 11'h000, 11'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), tbl[i].cond, tbl[i].addr, tbl[i].rd, tbl[i].wr,
                 tbl[i].nzvc, tbl[i].ir, tbl[i].ack, tbl[i].na, tbl[i].mpc,
                 tbl[i].stall, tbl[i].mirn, tbl[i].err);

        // read acknowledged on the third WAIT cycle; Z sampled only at the advance
        step("ws.run", 3'd2, 11'h300, 1, 0, 4'h0, 32'h0, 0, 11'h010, 11'h010, 1, 1, 0);
        step("ws.w1",  3'd2, 11'h300, 1, 0, 4'h0, 32'h0, 0, 11'h010, 11'h010, 1, 1, 0);
        step("ws.w2",  3'd2, 11'h300, 1, 0, 4'h0, 32'h0, 0, 11'h010, 11'h010, 1, 1, 0);
        step("ws.ack", 3'd2, 11'h300, 1, 0, 4'h4, 32'h0, 1, 11'h300, 11'h010, 0, 0, 0);
        step("ws.nxt", 3'd0, 11'h000, 0, 0, 4'h0, 32'h0, 0, 11'h301, 11'h300, 0, 0, 0);

        do_timeout("to1", 11'h301, 1'b0);
        step("to1.after", 3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h7F1, 11'h7F0, 0, 0, 1);

        // asynchronous reset in the middle of a WAIT
        step("rw.run", 3'd0, 11'h0, 1, 0, 4'h0, 32'h0, 0, 11'h7F1, 11'h7F1, 1, 1, 1);
        step("rw.w1",  3'd0, 11'h0, 1, 0, 4'h0, 32'h0, 0, 11'h7F1, 11'h7F1, 1, 1, 1);
        #2 rst = 1'b1;
        #1 chk_out("rw.async", 11'h000, 11'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("rw.start", 3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h000, 11'h000, 0, 0, 0);
        step("rw.r1",    3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h001, 11'h000, 0, 0, 0);
        step("rw.r2",    3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h002, 11'h001, 0, 0, 0);

        // acknowledge coincides with the timeout cycle: normal advance, no error
        step("ak.run", 3'd0, 11'h0, 1, 0, 4'h0, 32'h0, 0, 11'h002, 11'h002, 1, 1, 0);
        for (int i = 1; i < 16; i++)
            step($sformatf("ak.w%0d", i), 3'd0, 11'h0, 1, 0, 4'h0, 32'h0, 0,
                 11'h002, 11'h002, 1, 1, 0);
        step("ak.w16", 3'd0, 11'h0, 1, 0, 4'h0, 32'h0, 1, 11'h003, 11'h002, 0, 0, 0);
        step("ak.nxt", 3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h004, 11'h003, 0, 0, 0);

        // two timeouts back to back: error sets and then stays set
        do_timeout("to2", 11'h004, 1'b0);
        do_timeout("to3", 11'h7F0, 1'b1);
        step("to3.after", 3'd0, 11'h0, 0, 0, 4'h0, 32'h0, 0, 11'h7F1, 11'h7F0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
